// File: rtl/instruction_store_pkg.sv
// rtl/instruction_store_pkg.sv - state type and helpers shared by the instruction store files
`include "architecture.vh"

package instruction_store_pkg;

    localparam int INST_W = `INSTRUCTION_SIZE;
    localparam int ADDR_W = `ADDRESS_SIZE;

    typedef enum logic [1:0] {
        EMPTY = `STATE_EMPTY,
        LOAD  = `STATE_LOAD,
        RUN   = `STATE_RUN
    } state_t;

    function automatic logic even_parity(input logic [INST_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/architecture.vh
// rtl/architecture.vh - shared instruction/address widths, NOP word and store FSM encodings
`ifndef ARCHITECTURE_VH
`define ARCHITECTURE_VH

`define INSTRUCTION_SIZE 32
`define ADDRESS_SIZE     8
`define NOP_INST         32'h0000_0013

`define STATE_EMPTY      2'd0
`define STATE_LOAD       2'd1
`define STATE_RUN        2'd2

`endif

// File: rtl/instruction_ram.sv
// rtl/instruction_ram.sv - program storage, one synchronous write port and one asynchronous read port
module instruction_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
) (
    input  logic             clock,
    input  logic             write_enable,
    input  logic [IDX_W-1:0] write_address,
    input  logic [WIDTH-1:0] write_data,
    input  logic [IDX_W-1:0] read_address,
    output logic [WIDTH-1:0] read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
    end

    assign read_data = mem[read_address];

endmodule

// File: rtl/instruction_store.sv
// rtl/instruction_store.sv - loadable instruction memory feeding the fetch stage
// Optional read-parity checking is built when PARITY_CHECK_EN is defined.
`include "architecture.vh"

module instruction_store
    import instruction_store_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [`ADDRESS_SIZE-1:0]     pc,
    output logic [`INSTRUCTION_SIZE-1:0] instruction,
    output logic                         halt,
    input  logic                         load_start,
    input  logic                         load_valid,
    input  logic [`INSTRUCTION_SIZE-1:0] load_data,
    input  logic                         load_last,
    output logic                         load_ready,
    output logic                         overflow,
    output logic                         parity_error
);

    // Pointer and count carry one extra bit so DEPTH == 2^ADDRESS_SIZE is representable.
    localparam int PW    = ADDR_W + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

`ifdef PARITY_CHECK_EN
    localparam int RAM_W = INST_W + 1;
`else
    localparam int RAM_W = INST_W;
`endif

    state_t          state;
    logic [PW-1:0]   write_pointer;
    logic [PW-1:0]   word_count;
    logic            transfer;
    logic            room;
    logic            in_range;
    logic            parity_bad;
    logic [RAM_W-1:0] write_word;
    logic [RAM_W-1:0] read_word;

    assign transfer = load_valid && load_ready;
    assign room     = (write_pointer < DEPTH_P);
    assign in_range = ({1'b0, pc} < word_count);

`ifdef PARITY_CHECK_EN
    assign write_word = {even_parity(load_data), load_data};
    assign parity_bad = ^read_word;
`else
    assign write_word = load_data;
    assign parity_bad = 1'b0;
`endif

    instruction_ram #(
        .DEPTH (DEPTH),
        .WIDTH (RAM_W),
        .IDX_W (IDX_W)
    ) u_ram (
        .clock         (clock),
        .write_enable  (transfer && !load_start && room),
        .write_address (write_pointer[IDX_W-1:0]),
        .write_data    (write_word),
        .read_address  (pc[IDX_W-1:0]),
        .read_data     (read_word)
    );

    // Zero-latency read: the fetch stage samples instruction on the same edge as pc.
    assign instruction = (state == RUN && in_range && !parity_bad)
                         ? read_word[INST_W-1:0] : `NOP_INST;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= EMPTY;
            write_pointer <= '0;
            word_count    <= '0;
            overflow      <= 1'b0;
            halt          <= 1'b1;
            load_ready    <= 1'b0;
        end else if (load_start) begin
            state         <= LOAD;
            write_pointer <= '0;
            word_count    <= '0;
            overflow      <= 1'b0;
            halt          <= 1'b1;
            load_ready    <= 1'b1;
        end else begin
            case (state)
                EMPTY: ;
                LOAD: begin
                    if (transfer) begin
                        if (room) begin
                            write_pointer <= write_pointer + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (load_last) begin
                            state      <= RUN;
                            halt       <= 1'b0;
                            load_ready <= 1'b0;
                            word_count <= room ? write_pointer + 1'b1 : DEPTH_P;
                        end
                    end
                end
                RUN: ;
                default: begin
                    state      <= EMPTY;
                    halt       <= 1'b1;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            parity_error <= 1'b0;
        end else if (load_start) begin
            parity_error <= 1'b0;
        end else if (state == RUN && in_range && parity_bad) begin
            parity_error <= 1'b1;
        end
    end
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_store.sv
// tb/tb_instruction_store.sv - directed self-checking bench for instruction_store (DEPTH=16)
module tb_instruction_store;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic [7:0]  pc;
    logic [31:0] instruction;
    logic        halt;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        overflow;
    logic        parity_error;

    int checks = 0;
    int errors = 0;

    instruction_store #(.DEPTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .pc           (pc),
        .instruction  (instruction),
        .halt         (halt),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .overflow     (overflow),
        .parity_error (parity_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input logic [31:0] expected);
        pc = addr;
        #1;
        check(tag, instruction, expected);
    endtask

    initial begin
        reset      = 1'b0;
        pc         = 8'd0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'd0;
        load_last  = 1'b0;
        step();
        step();
        check("rst_halt", {31'd0, halt}, 32'd1);
        check("rst_ready", {31'd0, load_ready}, 32'd0);
        check("rst_inst", instruction, NOP);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_perr", {31'd0, parity_error}, 32'd0);

        reset = 1'b1;
        repeat (5) step();
        check("idle_halt", {31'd0, halt}, 32'd1);
        check("idle_ready", {31'd0, load_ready}, 32'd0);
        check("idle_inst", instruction, NOP);

        // three-word program
        start_load();
        check("load_ready", {31'd0, load_ready}, 32'd1);
        check("load_halt", {31'd0, halt}, 32'd1);
        send_word(32'h11, 1'b0);
        send_word(32'h22, 1'b0);
        check("pre_last_halt", {31'd0, halt}, 32'd1);
        read_check("load_inst_nop", 8'd0, NOP);
        send_word(32'h33, 1'b1);
        check("run_halt", {31'd0, halt}, 32'd0);
        check("run_ready", {31'd0, load_ready}, 32'd0);
        read_check("p3_pc0", 8'd0, 32'h11);
        read_check("p3_pc1", 8'd1, 32'h22);
        read_check("p3_pc2", 8'd2, 32'h33);
        read_check("p3_pc3", 8'd3, NOP);

        // overflow: 18 words into a 16-deep store
        start_load();
        for (int i = 0; i < 18; i++) begin
            send_word(32'h100 + i, (i == 17));
        end
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_halt", {31'd0, halt}, 32'd0);
        read_check("ovf_pc0", 8'd0, 32'h100);
        read_check("ovf_pc15", 8'd15, 32'h10F);
        read_check("ovf_pc16", 8'd16, NOP);
        read_check("ovf_pc17", 8'd17, NOP);

        // restart from RUN, start+transfer collision discards the word
        pc = 8'd0;
        start_load();
        check("restart_halt", {31'd0, halt}, 32'd1);
        check("restart_ovf", {31'd0, overflow}, 32'd0);
        check("restart_inst", instruction, NOP);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'hEE;
        load_last  = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("collide_halt", {31'd0, halt}, 32'd1);
        check("collide_ready", {31'd0, load_ready}, 32'd1);
        send_word(32'hAB, 1'b1);
        check("one_halt", {31'd0, halt}, 32'd0);
        read_check("one_pc0", 8'd0, 32'hAB);
        read_check("one_pc1", 8'd1, NOP);

        // reset in the middle of a load
        start_load();
        send_word(32'h61, 1'b0);
        send_word(32'h62, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_halt", {31'd0, halt}, 32'd1);
        check("mid_rst_ready", {31'd0, load_ready}, 32'd0);
        read_check("mid_rst_inst", 8'd0, NOP);
        step();
        reset = 1'b1;
        step();
        check("post_rst_ready", {31'd0, load_ready}, 32'd0);
        check("post_rst_halt", {31'd0, halt}, 32'd1);
        start_load();
        check("reload_ready", {31'd0, load_ready}, 32'd1);
        send_word(32'h55, 1'b1);
        read_check("reload_pc0", 8'd0, 32'h55);
        read_check("reload_pc1", 8'd1, NOP);

`ifdef PARITY_CHECK_EN
        start_load();
        send_word(32'hA1, 1'b0);
        send_word(32'hA2, 1'b0);
        send_word(32'hA3, 1'b1);
        dut.u_ram.mem[1] = dut.u_ram.mem[1] ^ 33'd1;
        read_check("par_pc1", 8'd1, NOP);
        step();
        check("par_flag", {31'd0, parity_error}, 32'd1);
        read_check("par_pc0", 8'd0, 32'hA1);
        step();
        check("par_sticky", {31'd0, parity_error}, 32'd1);
        start_load();
        check("par_clear", {31'd0, parity_error}, 32'd0);
`else
        check("par_tied", {31'd0, parity_error}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_store.md
INSTRUCTION_STORE -- requirements
Module: instruction_store

Interface
REQ-001 Parameter DEPTH, default 256, number of instruction words held; SHALL be ≤ 2^`ADDRESS_SIZE.
REQ-002 Port clock  input  1  rising-edge clock.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port pc  input  `ADDRESS_SIZE  fetch address from the fetch stage.
REQ-005 Port instruction  output  `INSTRUCTION_SIZE  word returned for pc.
REQ-006 Port halt  output  1  freezes the fetch stage while no valid program is present.
REQ-007 Port load_start  input  1  one-cycle request to begin a new program load.
REQ-008 Port load_valid  input  1  load_data is valid.
REQ-009 Port load_data  input  `INSTRUCTION_SIZE  program word.
REQ-010 Port load_last  input  1  marks the final word of a load, qualified by load_valid.
REQ-011 Port load_ready  output  1  the store accepts a load word this cycle.
REQ-012 Port overflow  output  1  sticky flag: a load exceeded DEPTH words.
REQ-013 Port parity_error  output  1  sticky read-parity error flag.

Function
REQ-014 FSM states: EMPTY, LOAD, RUN; state, write pointer, word count and flags SHALL be registered.
REQ-015 EMPTY: halt=1, load_ready=0; load_start -> LOAD.
REQ-016 LOAD: halt=1, load_ready=1; a word transfers on load_valid && load_ready.
REQ-017 Each transfer writes load_data at write pointer, then increments the pointer; load_last on a transfer -> RUN the next cycle, count = words written.
REQ-018 Transfers with pointer ≥ DEPTH are accepted but discarded, and set overflow; count saturates at DEPTH.
REQ-019 load_start in LOAD or RUN SHALL restart: pointer=0, count=0, overflow cleared, state LOAD; halt=1 from the next cycle.
REQ-020 load_start and a transfer in the same cycle: load_start wins, and the word is discarded.
REQ-021 RUN: halt=0, load_ready=0; instruction = mem[pc] combinationally, with zero-cycle latency, because the fetch stage samples it on the same edge as pc.
REQ-022 instruction SHALL be `NOP_INST when state ≠ RUN or pc ≥ count.
REQ-023 No state change occurs in RUN except via load_start; pc wrap-around is the fetch stage's concern; out-of-range pc is covered by REQ-022.

Reset
REQ-024 Asynchronous reset SHALL force: state=EMPTY, pointer=0, count=0, overflow=0, parity_error=0, halt=1, load_ready=0, instruction=`NOP_INST.
REQ-025 Reset mid-load SHALL abandon the load, and the program SHALL be treated as absent (count=0); storage array contents are not reset.

Configuration
REQ-026 Macro PARITY_CHECK_EN defined: each stored word carries one even-parity bit computed at write.
REQ-027 When PARITY_CHECK_EN is defined, a RUN-state read with pc < count and mismatched parity SHALL output `NOP_INST and set parity_error (sticky until reset or load_start).
REQ-028 Macro undefined: no parity storage is built; parity_error SHALL be tied 0, and the port remains present.

Structure
REQ-029 `INSTRUCTION_SIZE, `ADDRESS_SIZE, `NOP_INST and the FSM state encodings SHALL live in the shared architecture.vh.
REQ-030 Storage SHALL be a sub-module instruction_ram: one synchronous write port and one asynchronous read port, with width `INSTRUCTION_SIZE (+1 with PARITY_CHECK_EN).

Verification (DEPTH=16)
REQ-031 Reset then idle 5 cycles -> halt=1, load_ready=0, instruction=`NOP_INST for pc=0.
REQ-032 Load 0x11,0x22,0x33 with last on 0x33 -> RUN; pc=0..2 gives 0x11/0x22/0x33, and pc=3 gives `NOP_INST; halt falls one cycle after the last transfer.
REQ-033 Load 18 words -> overflow=1, count=16; pc=15 gives word 15, and words 16–17 are absent.
REQ-034 In RUN, pulse load_start -> halt=1 next cycle, overflow cleared; new 1-word load 0xAB -> pc=0 gives 0xAB, and pc=1 gives `NOP_INST.
REQ-035 Assert reset after 2 of 4 load words -> EMPTY, count=0; a subsequent load_start enters LOAD with pointer 0.
REQ-036 With PARITY_CHECK_EN, force a flipped stored bit at address 1 -> pc=1 gives `NOP_INST and parity_error=1 until the next load_start.
